// File: rtl/ltsm_sb_responder_pkg.sv
// Shared sideband definitions: training states, substates, message codes and decode helpers.
package ltsm_sb_responder_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned SUBSTATE_W = 4;
    localparam int unsigned CODE_W     = 4;

    // Local link training state encoding
    typedef enum logic [STATE_W-1:0] {
        ST_RESET      = 3'd0,
        ST_SBINIT     = 3'd1,
        ST_MBINIT     = 3'd2,
        ST_MBTRAIN    = 3'd3,
        ST_LINKINIT   = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_PHYRETRAIN = 3'd6,
        ST_TRAINERROR = 3'd7
    } state_e;

    // MBINIT substates
    typedef enum logic [SUBSTATE_W-1:0] {
        MBI_PARAM      = 4'd0,
        MBI_CAL        = 4'd1,
        MBI_REPAIRCLK  = 4'd2,
        MBI_REPAIRVAL  = 4'd3,
        MBI_REVERSALMB = 4'd4,
        MBI_REPAIRMB   = 4'd5
    } mbinit_sub_e;

    // MBTRAIN substates
    typedef enum logic [SUBSTATE_W-1:0] {
        MBT_VALREF           = 4'd0,
        MBT_DATAVREF         = 4'd1,
        MBT_SPEEDIDLE        = 4'd2,
        MBT_TXSELFCAL        = 4'd3,
        MBT_RXCLKCAL         = 4'd4,
        MBT_VALTRAINCENTER   = 4'd5,
        MBT_VALTRAINVREF     = 4'd6,
        MBT_DATATRAINCENTER1 = 4'd7,
        MBT_DATATRAINVREF    = 4'd8,
        MBT_RXDESKEW         = 4'd9,
        MBT_DATATRAINCENTER2 = 4'd10,
        MBT_LINKSPEED        = 4'd11,
        MBT_REPAIR           = 4'd12
    } mbtrain_sub_e;

    // SBINIT messages
    typedef enum logic [CODE_W-1:0] {
        SBI_MSG_NONE     = 4'd0,
        SBI_DONE_REQ     = 4'd1,
        SBI_DONE_RESP    = 4'd2,
        SBI_OUT_OF_RESET = 4'd3
    } sbinit_msg_e;

    // PHYRETRAIN messages
    typedef enum logic [CODE_W-1:0] {
        PRT_MSG_NONE   = 4'd0,
        PRT_START_REQ  = 4'd1,
        PRT_START_RESP = 4'd2
    } phyretrain_msg_e;

    localparam logic [CODE_W-1:0] SBINIT_OUT_OF_RESET = CODE_W'(SBI_OUT_OF_RESET);

    // Responder FSM states
    typedef enum logic [1:0] {
        FSM_IDLE       = 2'd0,
        FSM_WAIT_LOCAL = 2'd1,
        FSM_SEND       = 2'd2
    } fsm_e;

    // Captured sideband message payload
    typedef struct packed {
        state_e                state;
        logic [SUBSTATE_W-1:0] substate;
        logic [CODE_W-1:0]     code;
    } sb_msg_t;

    // States whose messages are qualified by substate
    function automatic logic is_mb_state(state_e st);
        return (st == ST_MBINIT) || (st == ST_MBTRAIN);
    endfunction

    // Highest legal message code for a state/substate; 0 means no messages accepted
    function automatic logic [CODE_W-1:0] max_code(state_e st, logic [SUBSTATE_W-1:0] sub);
        logic [CODE_W-1:0] mx;
        mx = 4'd0;
        case (st)
            ST_SBINIT:     mx = 4'd3;
            ST_PHYRETRAIN: mx = 4'd2;
            ST_MBINIT: begin
                case (sub)
                    MBI_PARAM, MBI_CAL:                         mx = 4'd2;
                    MBI_REPAIRCLK, MBI_REPAIRVAL, MBI_REPAIRMB: mx = 4'd6;
                    MBI_REVERSALMB:                             mx = 4'd8;
                    default:                                    mx = 4'd0;
                endcase
            end
            ST_MBTRAIN: begin
                case (sub)
                    MBT_SPEEDIDLE, MBT_TXSELFCAL: mx = 4'd2;
                    MBT_LINKSPEED:                mx = 4'd10;
                    MBT_REPAIR:                   mx = 4'd8;
                    default:                      mx = 4'd4;
                endcase
            end
            default: mx = 4'd0;
        endcase
        return mx;
    endfunction

    // Odd codes are requests
    function automatic logic is_req(logic [CODE_W-1:0] code);
        return code[0];
    endfunction

    // Response code paired with a request code
    function automatic logic [CODE_W-1:0] resp_of(logic [CODE_W-1:0] code);
        return code + 4'd1;
    endfunction

endpackage

// File: rtl/sb_msg_validator.sv
// Combinational validity and class decode of a received sideband message.
module sb_msg_validator
    import ltsm_sb_responder_pkg::*;
(
    input  logic [STATE_W-1:0]    cur_state_i,
    input  logic [SUBSTATE_W-1:0] cur_substate_i,
    input  logic                  rx_valid_i,
    input  logic [STATE_W-1:0]    rx_state_i,
    input  logic [SUBSTATE_W-1:0] rx_substate_i,
    input  logic [CODE_W-1:0]     rx_code_i,
    output logic                  valid_c_o,
    output logic                  is_req_c_o,
    output logic                  is_resp_c_o,
    output logic                  is_oor_c_o
);

    state_e cur_st_c;
    logic   state_match_c;
    logic   sub_match_c;
    logic   code_ok_c;
    logic   oor_c;

    // Message must target the local state/substate with an in-range code
    always_comb begin
        cur_st_c      = state_e'(cur_state_i);
        state_match_c = (rx_state_i == cur_state_i);
        sub_match_c   = !is_mb_state(cur_st_c) || (rx_substate_i == cur_substate_i);
        code_ok_c     = (rx_code_i != 4'd0) && (rx_code_i <= max_code(cur_st_c, cur_substate_i));
        valid_c_o     = rx_valid_i && state_match_c && sub_match_c && code_ok_c;
        oor_c         = (cur_st_c == ST_SBINIT) && (rx_code_i == SBINIT_OUT_OF_RESET);
        is_oor_c_o    = valid_c_o && oor_c;
        is_req_c_o    = valid_c_o && is_req(rx_code_i) && !oor_c;
        is_resp_c_o   = valid_c_o && !is_req(rx_code_i);
    end

endmodule

// File: rtl/ltsm_sb_responder.sv
// Partner-side sideband responder: answers REQs once local work is ready, forwards RESPs, flags bad traffic.
module ltsm_sb_responder
    import ltsm_sb_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8000000,
    parameter int unsigned CNT_W          = 23
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [STATE_W-1:0]    i_cur_state,
    input  logic [SUBSTATE_W-1:0] i_cur_substate,
    input  logic                  i_rx_valid,
    input  logic [STATE_W-1:0]    i_rx_state,
    input  logic [SUBSTATE_W-1:0] i_rx_substate,
    input  logic [CODE_W-1:0]     i_rx_code,
    input  logic                  i_local_ready,
    input  logic                  i_tx_ready,
    output logic                  o_tx_valid,
    output logic [STATE_W-1:0]    o_tx_state,
    output logic [SUBSTATE_W-1:0] o_tx_substate,
    output logic [CODE_W-1:0]     o_tx_code,
    output logic                  o_req_pending,
    output logic [CODE_W-1:0]     o_req_code,
    output logic                  o_resp_valid,
    output logic [CODE_W-1:0]     o_resp_code,
    output logic                  o_partner_oor,
    output logic                  o_unexpected,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    fsm_e              state_q, state_d;
    sb_msg_t           cap_q, cap_d;
    logic [CODE_W-1:0] tx_code_q, tx_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic              pending_q, pending_d;
    logic              resp_valid_q, resp_valid_d;
    logic [CODE_W-1:0] resp_code_q, resp_code_d;
    logic              oor_q, oor_d;
    logic              unexp_q, unexp_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic   msg_valid_c;
    logic   msg_req_c;
    logic   msg_resp_c;
    logic   msg_oor_c;
    logic   abort_c;
    logic   new_req_c;
    state_e cur_st_c;

    sb_msg_validator u_validator (
        .cur_state_i    (i_cur_state),
        .cur_substate_i (i_cur_substate),
        .rx_valid_i     (i_rx_valid),
        .rx_state_i     (i_rx_state),
        .rx_substate_i  (i_rx_substate),
        .rx_code_i      (i_rx_code),
        .valid_c_o      (msg_valid_c),
        .is_req_c_o     (msg_req_c),
        .is_resp_c_o    (msg_resp_c),
        .is_oor_c_o     (msg_oor_c)
    );

    // Next-state, capture and flag logic
    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        tx_code_d    = tx_code_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_code_d  = resp_code_q;
        unexp_d      = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;

        cur_st_c  = state_e'(i_cur_state);
        // Local training moved away from the state the pending REQ belongs to
        abort_c   = (cur_st_c != cap_q.state) ||
                    (is_mb_state(cap_q.state) && (i_cur_substate != cap_q.substate));
        new_req_c = msg_req_c && (i_rx_code != cap_q.code);

        // Partner out-of-reset is only meaningful while we are still in SBINIT
        oor_d = (oor_q && (cur_st_c == ST_SBINIT)) || msg_oor_c;

        if (i_rx_valid && !msg_valid_c) begin
            unexp_d = 1'b1;
        end
        if (msg_resp_c) begin
            resp_valid_d = 1'b1;
            resp_code_d  = i_rx_code;
        end

        case (state_q)
            FSM_IDLE: begin
                if (msg_req_c) begin
                    cap_d.state    = state_e'(i_rx_state);
                    cap_d.substate = i_rx_substate;
                    cap_d.code     = i_rx_code;
                    tx_code_d      = resp_of(i_rx_code);
                    cnt_d          = '0;
                    state_d        = FSM_WAIT_LOCAL;
                end
            end
            FSM_WAIT_LOCAL: begin
                overrun_d = new_req_c;
                if (abort_c) begin
                    state_d = FSM_IDLE;
                end else if (i_local_ready) begin
                    state_d = FSM_SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = FSM_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FSM_SEND: begin
                overrun_d = new_req_c;
                // A completed handshake stands even if training moves on that cycle
                if (i_tx_ready || abort_c) begin
                    state_d = FSM_IDLE;
                end
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase

        tx_valid_d = (state_d == FSM_SEND);
        pending_d  = (state_d == FSM_WAIT_LOCAL);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= FSM_IDLE;
            cap_q        <= '0;
            tx_code_q    <= '0;
            cnt_q        <= '0;
            tx_valid_q   <= 1'b0;
            pending_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= '0;
            oor_q        <= 1'b0;
            unexp_q      <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            tx_code_q    <= tx_code_d;
            cnt_q        <= cnt_d;
            tx_valid_q   <= tx_valid_d;
            pending_q    <= pending_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            oor_q        <= oor_d;
            unexp_q      <= unexp_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_tx_valid    = tx_valid_q;
    assign o_tx_state    = cap_q.state;
    assign o_tx_substate = cap_q.substate;
    assign o_tx_code     = tx_code_q;
    assign o_req_pending = pending_q;
    assign o_req_code    = cap_q.code;
    assign o_resp_valid  = resp_valid_q;
    assign o_resp_code   = resp_code_q;
    assign o_partner_oor = oor_q;
    assign o_unexpected  = unexp_q;
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;

endmodule

// File: doc/ltsm_sb_responder.md
# ltsm_sb_responder

Partner-side sideband responder for the LTSM handshake protocol: decodes incoming sideband REQ messages against the local training state, waits for local readiness, and returns the matching RESP. It sits between the sideband RX decoder and the sideband TX arbiter, alongside the initiator logic that issues REQs. It also forwards received RESPs and flags out-of-sequence traffic.

## Interface
- TIMEOUT_CYCLES, default 8000000: maximum cycles in WAIT_LOCAL before abort (8 ms at 1 GHz).
- CNT_W, default 23: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (direction, width, meaning):
- i_clk  in  1  block clock; one clock domain.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cur_state  in  3  local state_e encoding.
- i_cur_substate  in  4  local MBINIT/MBTRAIN substate encoding; ignored in other states.
- i_rx_valid  in  1  one-cycle strobe: decoded message present.
- i_rx_state, i_rx_substate, i_rx_code  in  3/4/4  fields of the received message.
- i_local_ready  in  1  level: local side has completed the work the pending REQ requires.
- i_tx_ready  in  1  TX arbiter accepts the response.
- o_tx_valid  out  1  response pending.
- o_tx_state, o_tx_substate, o_tx_code  out  3/4/4  response fields.
- o_req_pending  out  1  a REQ is captured and awaiting i_local_ready.
- o_req_code  out  4  captured REQ code.
- o_resp_valid  out  1  pulse: a valid RESP was received.
- o_resp_code  out  4  code of that RESP.
- o_partner_oor  out  1  sticky: SBINIT_OUT_OF_RESET received; cleared when the local state leaves SBINIT.
- o_unexpected  out  1  pulse: message invalid for the current state.
- o_overrun  out  1  pulse: a different REQ arrived while busy.
- o_timeout  out  1  pulse: WAIT_LOCAL exceeded TIMEOUT_CYCLES.

## Operation
- Message validity requires all of the following:
  - i_rx_state equals i_cur_state.
  - For MBINIT and MBTRAIN, i_rx_substate equals i_cur_substate.
  - 1 ≤ code ≤ MAX_CODE for the state/substate.
  - RESET, LINKINIT, ACTIVE and TRAINERROR accept no messages; any message in these states is unexpected.
- MAX_CODE values:
  - SBINIT 3; PHYRETRAIN 2.
  - MBINIT: PARAM 2, CAL 2, REPAIRCLK 6, REPAIRVAL 6, REVERSALMB 8, REPAIRMB 6.
  - MBTRAIN: SPEEDIDLE 2, TXSELFCAL 2, LINKSPEED 10, REPAIR 8; all other MBTRAIN substates 4.
- Code classes:
  - Odd codes are REQs; the response code is REQ+1.
  - Exception: SBINIT code 3 (OUT_OF_RESET) gets no response and only sets o_partner_oor.
  - Even codes are RESPs: o_resp_valid/o_resp_code pulse, in every FSM state.
- FSM states: IDLE, WAIT_LOCAL, SEND.
  - IDLE: on a valid REQ, capture state/substate/code, clear the counter, go to WAIT_LOCAL.
  - WAIT_LOCAL: o_req_pending=1. If i_local_ready, go to SEND. If counter reaches TIMEOUT_CYCLES, pulse o_timeout and go to IDLE. The counter increments each cycle.
  - SEND: o_tx_valid=1 with captured state/substate and code+1. On i_tx_ready, go to IDLE.
- Duplicate REQ (same code) while in WAIT_LOCAL or SEND: ignored silently (retransmission).
- Different valid REQ while busy: dropped, o_overrun pulse.
- If i_cur_state or i_cur_substate (where relevant) differs from the captured value while in WAIT_LOCAL or SEND: abort to IDLE with no response and no flag.
- Invalid message in any FSM state: o_unexpected pulse; FSM unchanged.

## Timing
- Reset: FSM IDLE; all outputs 0; counter 0.
- i_rx_valid at cycle N → o_req_pending high at N+1.
- i_local_ready first seen high at cycle M in WAIT_LOCAL → o_tx_valid high at M+1.
- If i_local_ready is already high at N+1, o_tx_valid rises at N+2 (minimum latency 2).
- o_tx_valid and the tx fields are stable until the cycle i_tx_ready is sampled high. o_tx_valid is low the following cycle.
- A new REQ on the same cycle as the i_tx_ready handshake counts as busy. It is retransmission if the code matches, overrun otherwise.
- o_resp_valid, o_unexpected, o_overrun and o_timeout are registered one-cycle pulses, one cycle after the causing event.
- Timeout fires when the counter equals TIMEOUT_CYCLES. i_local_ready on that same cycle wins (go to SEND).
- Asynchronous reset mid-operation discards the pending REQ immediately; no response is sent.

## Structure
- The shared sideband package holds:
  - State, substate and per-substate message enums.
  - MAX_CODE lookup function (state, substate) → 4-bit.
  - Helper functions is_req(code) and resp_of(code).
  - The SBINIT_OUT_OF_RESET constant.
- Sub-module sb_msg_validator: combinational validity and class decode (valid, is_req, is_resp, is_oor) feeding the FSM.

## Test plan
- MBINIT/CAL, rx code 1, i_local_ready held high → o_tx_valid at N+2 with code 2, state MBINIT, substate CAL; i_tx_ready → idle.
- MBTRAIN/LINKSPEED, REQ code 9, ready after 50 cycles, then code 9 repeated → single response, code 10; no o_overrun.
- While WAIT_LOCAL on REPAIRMB code 1, receive code 5 → o_overrun pulse; the response stays code 2.
- SBINIT code 3 → o_partner_oor=1 and no tx. Local state moves to MBINIT → o_partner_oor cleared.
- MBTRAIN/VALREF code 5, or any message in ACTIVE → o_unexpected pulse. MBINIT/PARAM code 2 → o_resp_valid with code 2.
- TIMEOUT_CYCLES=10 with i_local_ready low → o_timeout after 10 WAIT cycles. Separately, a substate change during WAIT and i_rst_n low during SEND → abort and outputs 0.
